// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch unit.
package fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      DRAIN,
      HOLD,
      ERR
   } fetch_state_t;

   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return addr[$clog2(INSTR_BYTES)-1:0] == '0;
   endfunction

endpackage

// File: rtl/fetch_timer.sv
// Request watchdog: clears on launch, counts stalled REQ/DRAIN cycles,
// flags the last allowed cycle through tc.
module fetch_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic clear,
   input  logic count_en,
   output logic tc
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)          count_q <= '0;
      else if (clear)    count_q <= '0;
      else if (count_en) count_q <= count_q + W'(1);
   end

   // Asserted on the TIMEOUT_CYCLES-th consecutive cycle without an ack.
   assign tc = count_en && (count_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit between pc and decode; one word read per instruction.
// Optional request timeout watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            en,
   input  logic [XLEN-1:0] pc_val,
   input  logic            flush,
   output logic            pc_inc,
   output logic            fetch_stall,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic            misalign_err,
   output logic            fetch_err
);

   fetch_state_t state_q, state_d;
   logic         launch;
   logic         capture;
   logic         set_mis;
   logic         timeout;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("instr_fetch: TIMEOUT_CYCLES must be nonzero");
   end

`ifdef FETCH_TIMEOUT_EN
   fetch_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .clr     (clr),
      .clear   (launch),
      .count_en(mem_req && !mem_ack),
      .tc      (timeout)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)        fetch_err <= 1'b0;
      else if (timeout) fetch_err <= 1'b1;
   end
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      launch      = 1'b0;
      capture     = 1'b0;
      set_mis     = 1'b0;
      mem_req     = 1'b0;
      instr_valid = 1'b0;
      pc_inc      = 1'b0;
      fetch_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && !flush) begin
               if (is_aligned(pc_val)) begin
                  launch  = 1'b1;
                  state_d = REQ;
               end else begin
                  set_mis = 1'b1;
                  state_d = ERR;
               end
            end
         end
         REQ: begin
            mem_req     = 1'b1;
            fetch_stall = 1'b1;
            // An ack on the terminal-count cycle takes priority over timeout.
            if (mem_ack) begin
               capture = !flush;
               state_d = flush ? IDLE : HOLD;
            end else if (timeout) begin
               state_d = ERR;
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            mem_req     = 1'b1;
            fetch_stall = 1'b1;
            if (mem_ack)      state_d = IDLE;
            else if (timeout) state_d = ERR;
         end
         HOLD: begin
            instr_valid = 1'b1;
            pc_inc      = instr_ready && !flush;
            fetch_stall = !pc_inc;
            if (pc_inc || flush) state_d = IDLE;
         end
         ERR: begin
            fetch_stall = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         mem_addr     <= '0;
         instr        <= '0;
         misalign_err <= 1'b0;
      end else begin
         if (launch)  mem_addr     <= pc_val;
         if (capture) instr        <= mem_rdata;
         if (set_mis) misalign_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC model and an instruction scoreboard.
// Define FETCH_TIMEOUT_EN to also exercise the timeout watchdog.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        clr, en, flush, mem_ack, instr_ready;
   logic [31:0] pc_val, mem_rdata, mem_addr, instr;
   logic        pc_inc, fetch_stall, mem_req, instr_valid, misalign_err, fetch_err;

   logic        pc_load;
   logic [31:0] pc_load_val, pc_reg;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   instr_fetch #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .en          (en),
      .pc_val      (pc_val),
      .flush       (flush),
      .pc_inc      (pc_inc),
      .fetch_stall (fetch_stall),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .misalign_err(misalign_err),
      .fetch_err   (fetch_err)
   );

   // Program counter: branch-target load wins over increment.
   always @(posedge clk or negedge clr) begin
      if (!clr)         pc_reg <= 32'd0;
      else if (pc_load) pc_reg <= pc_load_val;
      else if (pc_inc)  pc_reg <= pc_reg + 32'd4;
   end
   assign pc_val = pc_reg;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every presented word must be the oldest expected one; it retires on
   // acceptance or flush.
   always @(negedge clk) begin
      if (clr === 1'b1 && instr_valid === 1'b1) begin
         check("word_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check("instr", instr, exp_q[0]);
            if (flush || instr_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      clr = 1'b0; en = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      instr_ready = 1'b0; pc_load = 1'b0; pc_load_val = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_pc_inc", pc_inc, 0);
      check("rst_stall", fetch_stall, 0);
      check("rst_misalign", misalign_err, 0);
      check("rst_fetch_err", fetch_err, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_instr", instr, 0);

      // Reset and launch
      clr = 1'b1; en = 1'b1; instr_ready = 1'b1;
      #1;
      check("idle_stall", fetch_stall, 0);
      step();
      check("req1_mem_req", mem_req, 1);
      check("req1_addr", mem_addr, 32'd0);
      check("req1_stall", fetch_stall, 1);
      mem_ack = 1'b1; mem_rdata = 32'h00500093; exp_q.push_back(32'h00500093);
      step();
      mem_ack = 1'b0;
      #1;
      check("hold1_valid", instr_valid, 1);
      check("hold1_pc_inc", pc_inc, 1);
      check("hold1_stall", fetch_stall, 0);
      step();
      check("idle2_pc", pc_val, 32'd4);
      check("idle2_mem_req", mem_req, 0);
      step();
      check("req2_addr", mem_addr, 32'd4);

      // Decoder backpressure
      instr_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00a00113;
      exp_q.push_back(32'h00a00113);
      step();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_valid", instr_valid, 1);
         check("bp_stall", fetch_stall, 1);
         check("bp_pc_inc", pc_inc, 0);
         step();
      end
      instr_ready = 1'b1;
      #1;
      check("bp_release_pc_inc", pc_inc, 1);
      check("bp_release_stall", fetch_stall, 0);
      step();
      check("bp_one_inc_pc", pc_val, 32'd8);
      check("bp_idle_pc_inc", pc_inc, 0);
      step();
      check("req3_addr", mem_addr, 32'd8);

      // Flush while waiting, ack two cycles later
      flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'd40;
      #1;
      check("req_flush_pc_inc", pc_inc, 0);
      step();
      flush = 1'b0; pc_load = 1'b0;
      #1;
      check("drain_mem_req", mem_req, 1);
      check("drain_valid", instr_valid, 0);
      check("drain_stall", fetch_stall, 1);
      check("drain_pc", pc_val, 32'd40);
      step();
      check("drain2_mem_req", mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'hdeadbeef;
      step();
      mem_ack = 1'b0;
      #1;
      check("post_drain_mem_req", mem_req, 0);
      check("post_drain_valid", instr_valid, 0);
      step();
      check("req4_addr", mem_addr, 32'd40);

      // Flush in HOLD with decoder ready
      mem_ack = 1'b1; mem_rdata = 32'h11111111; exp_q.push_back(32'h11111111);
      step();
      mem_ack = 1'b0; flush = 1'b1; pc_load = 1'b1; pc_load_val = 32'd100;
      #1;
      check("hold_flush_valid", instr_valid, 1);
      check("hold_flush_pc_inc", pc_inc, 0);
      check("hold_flush_stall", fetch_stall, 1);
      step();
      // Flush in IDLE: remain idle for one cycle
      pc_load_val = 32'd200;
      #1;
      check("hold_flush_drop", instr_valid, 0);
      check("hold_flush_pc", pc_val, 32'd100);
      step();
      flush = 1'b0; pc_load = 1'b0;
      #1;
      check("idle_flush_hold", mem_req, 0);
      check("idle_flush_pc", pc_val, 32'd200);
      step();
      check("req5_mem_req", mem_req, 1);
      check("req5_addr", mem_addr, 32'd200);
      mem_ack = 1'b1; mem_rdata = 32'h00208233; exp_q.push_back(32'h00208233);
      step();
      mem_ack = 1'b0; pc_load = 1'b1; pc_load_val = 32'd6;
      #1;
      check("hold5_pc_inc", pc_inc, 1);

      // Misaligned PC
      step();
      pc_load = 1'b0;
      #1;
      check("mis_pc", pc_val, 32'd6);
      step();
      for (int i = 0; i < 3; i++) begin
         check("mis_err", misalign_err, 1);
         check("mis_mem_req", mem_req, 0);
         check("mis_valid", instr_valid, 0);
         check("mis_stall", fetch_stall, 1);
         step();
      end
      clr = 1'b0;
      #1;
      check("mis_cleared", misalign_err, 0);
      check("mis_rst_stall", fetch_stall, 0);

      // Reset mid-REQ drops the request at once
      step();
      clr = 1'b1;
      step();
      check("req6_mem_req", mem_req, 1);
      check("req6_addr", mem_addr, 32'd0);
      clr = 1'b0;
      #1;
      check("rst_mid_req", mem_req, 0);

`ifdef FETCH_TIMEOUT_EN
      // No ack: error after 4 REQ cycles
      step();
      clr = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         check("tmo_mem_req", mem_req, 1);
         check("tmo_err_low", fetch_err, 0);
         step();
      end
      check("tmo_err", fetch_err, 1);
      check("tmo_mem_req_drop", mem_req, 0);
      check("tmo_stall", fetch_stall, 1);
      clr = 1'b0;
      #1;
      check("tmo_cleared", fetch_err, 0);
      step();
      clr = 1'b1;
      step();
      repeat (3) step();
      // Ack on the terminal-count cycle wins
      mem_ack = 1'b1; mem_rdata = 32'h00c00193; exp_q.push_back(32'h00c00193);
      step();
      mem_ack = 1'b0;
      #1;
      check("tmo_ack_valid", instr_valid, 1);
      check("tmo_ack_no_err", fetch_err, 0);
      step();
`endif

      step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
